// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV64M multiply/divide sequencer with pipeline stall control
module muldiv_sequencer #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_addr_in,
   output logic            stall_req,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_addr_out,
   output logic            reg_write_out
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nx;

   logic [2:0]        op_q;
   logic [4:0]        rd_q;
   logic              neg_q;
   logic [XLEN-1:0]   b_q;
   logic [2*XLEN-1:0] acc;
   logic [CW-1:0]     cnt;
   logic [XLEN-1:0]   result_q;
   logic [4:0]        rd_out_q;

   // Operand decode in IDLE: signedness, magnitudes and special divide cases
   logic            a_signed, b_signed, sa, sb, neg_in, div_zero, div_ovf, special;
   logic [XLEN-1:0] a_abs, b_abs;
   logic [2*XLEN-1:0] special_acc;

   assign a_signed = funct3[2] ? !funct3[0] : (funct3 != 3'b011);
   assign b_signed = funct3[2] ? !funct3[0] : !funct3[1];
   assign sa       = a_signed & rs1_data[XLEN-1];
   assign sb       = b_signed & rs2_data[XLEN-1];
   assign a_abs    = sa ? (~rs1_data + 1'b1) : rs1_data;
   assign b_abs    = sb ? (~rs2_data + 1'b1) : rs2_data;
   assign neg_in   = (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
   assign div_zero = (rs2_data == {XLEN{1'b0}});
   assign div_ovf  = !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                     && (rs2_data == {XLEN{1'b1}});
   assign special  = funct3[2] && (div_zero || div_ovf);
   // Special results are preloaded as {remainder, quotient} so DONE selects them unchanged
   assign special_acc = div_zero ? {rs1_data, {XLEN{1'b1}}} : {{XLEN{1'b0}}, rs1_data};

   // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] mul_next, div_next;

   assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? b_q : {XLEN{1'b0}})};
   assign mul_next  = {mul_sum, acc[XLEN-1:1]};
   assign div_shift = acc[2*XLEN-1:XLEN-1];
   assign div_ge    = (div_shift >= {1'b0, b_q});
   assign div_diff  = div_shift - {1'b0, b_q};
   assign div_next  = div_ge ? {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1}
                             : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};

   logic [2*XLEN-1:0] mul_fin;
   logic [XLEN-1:0]   quo_fin, rem_fin, done_val;

   assign mul_fin = neg_q ? (~acc + 1'b1) : acc;
   assign quo_fin = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
   assign rem_fin = neg_q ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];

   always_comb begin
      done_val = {XLEN{1'b0}};
      case (op_q)
         3'b000:                  done_val = mul_fin[XLEN-1:0];
         3'b001, 3'b010, 3'b011:  done_val = mul_fin[2*XLEN-1:XLEN];
         3'b100, 3'b101:          done_val = quo_fin;
         default:                 done_val = rem_fin;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = special ? DONE : CALC;
         CALC:    if (cnt == CW'(XLEN-1)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= 3'b000;
         rd_q     <= 5'd0;
         neg_q    <= 1'b0;
         b_q      <= {XLEN{1'b0}};
         acc      <= {(2*XLEN){1'b0}};
         cnt      <= {CW{1'b0}};
         result_q <= {XLEN{1'b0}};
         rd_out_q <= 5'd0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (start && !flush) begin
               op_q  <= funct3;
               rd_q  <= rd_addr_in;
               b_q   <= b_abs;
               cnt   <= {CW{1'b0}};
               acc   <= special ? special_acc : {{XLEN{1'b0}}, a_abs};
               neg_q <= special ? 1'b0 : neg_in;
            end
            CALC: begin
               acc <= op_q[2] ? div_next : mul_next;
               cnt <= cnt + 1'b1;
            end
            DONE: if (!flush) begin
               result_q <= done_val;
               rd_out_q <= rd_q;
            end
            default: ;
         endcase
      end
   end

   assign stall_req     = ((state == IDLE) && start && !flush) || (state == CALC);
   assign busy          = (state != IDLE);
   assign result_valid  = (state == DONE) && !flush;
   assign result        = result_valid ? done_val : result_q;
   assign rd_addr_out   = result_valid ? rd_q : rd_out_q;
   assign reg_write_out = result_valid && (rd_q != 5'd0);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [63:0] rs1_data = 64'd0;
   logic [63:0] rs2_data = 64'd0;
   logic [4:0]  rd_addr_in = 5'd0;
   logic        stall_req, busy, result_valid, reg_write_out;
   logic [63:0] result;
   logic [4:0]  rd_addr_out;

   int tests = 0;
   int failed = 0;

   muldiv_sequencer #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr_in(rd_addr_in),
      .stall_req(stall_req), .busy(busy), .result_valid(result_valid),
      .result(result), .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  rd;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] ae, be, p;
      logic signed [63:0] sa, sb;
      sa = a;
      sb = b;
      case (f3)
         3'd0: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
         3'd1: begin ae = {{64{a[63]}}, a}; be = {{64{b[63]}}, b}; p = ae * be; return p[127:64]; end
         3'd2: begin ae = {{64{a[63]}}, a}; be = {64'd0, b}; p = ae * be; return p[127:64]; end
         3'd3: begin ae = {64'd0, a}; be = {64'd0, b}; p = ae * be; return p[127:64]; end
         3'd4: begin
            if (b == 64'd0) return ONES;
            if (a == MIN64 && b == ONES) return a;
            return sa / sb;
         end
         3'd5: return (b == 64'd0) ? ONES : a / b;
         3'd6: begin
            if (b == 64'd0) return a;
            if (a == MIN64 && b == ONES) return 64'd0;
            return sa % sb;
         end
         default: return (b == 64'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
      if (f3[2] && (b == 64'd0 || (!f3[0] && a == MIN64 && b == ONES))) return 1;
      return 65;
   endfunction

   task automatic do_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input bit flush_in_done,
                        output logic [63:0] res, output logic [4:0] rdo, output bit wr,
                        output int lat, output int stalls, output int nvalid);
      bit done;
      done = 0; res = '0; rdo = '0; wr = 0; lat = -1; nvalid = 0;
      @(negedge clk);
      funct3 = f3; rs1_data = a; rs2_data = b; rd_addr_in = rd; start = 1'b1; flush = 1'b0;
      #1 stalls = int'(stall_req);
      for (int c = 1; c <= 150 && !done; c++) begin
         @(negedge clk);
         start = 1'b0; flush = 1'b0;
         funct3 = 3'($urandom); rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
         #1;
         if (!busy) done = 1;
         else begin
            if (flush_in_done && !stall_req) begin flush = 1'b1; #1; end
            if (stall_req) stalls++;
            if (result_valid) begin
               nvalid++; res = result; rdo = rd_addr_out; wr = reg_write_out; lat = c;
            end
         end
      end
      flush = 1'b0;
      if (!done) check("timeout", 64'd1, 64'd0);
   endtask

   task automatic run_checked(input string name, input logic [2:0] f3, input logic [63:0] a,
                              input logic [63:0] b, input logic [4:0] rd,
                              input logic [63:0] exp, input int exp_lat);
      logic [63:0] res; logic [4:0] rdo; bit wr; int lat, stalls, nvalid;
      do_op(f3, a, b, rd, 1'b0, res, rdo, wr, lat, stalls, nvalid);
      check({name, " result"}, res, exp);
      check({name, " valid_count"}, nvalid, 1);
      check({name, " latency"}, lat, exp_lat);
      check({name, " stall_cycles"}, stalls, exp_lat);
      check({name, " rd_out"}, rdo, rd);
      check({name, " reg_write"}, wr, rd != 5'd0);
   endtask

   initial begin
      vec_t vecs[$];
      logic [63:0] res, a, b; logic [4:0] rdo, rd; bit wr; int lat, stalls, nvalid;
      logic [2:0] f3;

      vecs.push_back('{3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 65});
      vecs.push_back('{3'b011, ONES, ONES, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65});
      vecs.push_back('{3'b001, ONES, ONES, 5'd7, 64'd0, 65});
      vecs.push_back('{3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD, 65});
      vecs.push_back('{3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, ONES, 65});
      vecs.push_back('{3'b101, 64'd100, 64'd7, 5'd10, 64'd14, 65});
      vecs.push_back('{3'b101, 64'd55, 64'd0, 5'd11, ONES, 1});
      vecs.push_back('{3'b110, 64'd42, 64'd0, 5'd12, 64'd42, 1});
      vecs.push_back('{3'b100, MIN64, ONES, 5'd13, MIN64, 1});
      vecs.push_back('{3'b000, 64'd3, 64'd4, 5'd0, 64'd12, 65});

      repeat (2) @(negedge clk);
      #1;
      check("reset result", result, 64'd0);
      check("reset rd_out", rd_addr_out, 64'd0);
      check("reset valid", result_valid, 64'd0);
      check("reset busy", busy, 64'd0);
      check("reset stall", stall_req, 64'd0);
      check("reset reg_write", reg_write_out, 64'd0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         run_checked($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
                     vecs[i].exp, vecs[i].lat);

      // start together with flush in IDLE is dropped
      @(negedge clk);
      funct3 = 3'b000; rs1_data = 64'd9; rs2_data = 64'd9; start = 1'b1; flush = 1'b1;
      #1 check("flush_start stall", stall_req, 64'd0);
      @(negedge clk) start = 1'b0; flush = 1'b0;
      #1 check("flush_start busy", busy, 64'd0);

      // flush in CALC cycle 30
      @(negedge clk);
      funct3 = 3'b000; rs1_data = 64'd11; rs2_data = 64'd13; rd_addr_in = 5'd3; start = 1'b1;
      nvalid = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk) start = 1'b0;
         #1 if (result_valid) nvalid++;
      end
      flush = 1'b1;
      #1 if (result_valid) nvalid++;
      @(negedge clk) flush = 1'b0;
      #1;
      check("calc_flush busy", busy, 64'd0);
      check("calc_flush stall", stall_req, 64'd0);
      check("calc_flush no_valid", nvalid, 0);
      repeat (2) @(negedge clk);
      run_checked("after_flush", 3'b000, 64'd11, 64'd13, 5'd3, 64'd143, 65);

      // flush coincident with DONE suppresses the write
      do_op(3'b000, 64'd3, 64'd4, 5'd0, 1'b1, res, rdo, wr, lat, stalls, nvalid);
      check("done_flush valid_count", nvalid, 0);
      check("done_flush reg_write", wr, 64'd0);

      // async reset in the middle of CALC
      @(negedge clk);
      funct3 = 3'b100; rs1_data = 64'd1000; rs2_data = 64'd3; rd_addr_in = 5'd4; start = 1'b1;
      repeat (20) @(negedge clk) start = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midreset result", result, 64'd0);
      check("midreset rd_out", rd_addr_out, 64'd0);
      check("midreset busy", busy, 64'd0);
      check("midreset stall", stall_req, 64'd0);
      check("midreset valid", result_valid, 64'd0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(7));
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         rd = 5'($urandom_range(31));
         case ($urandom_range(5))
            0: b = 64'd0;
            1: begin a = MIN64; b = ONES; end
            2: begin
               a = 64'($urandom_range(200)); b = 64'($urandom_range(1, 20));
               if ($urandom_range(1)) a = ~a + 64'd1;
               if ($urandom_range(1)) b = ~b + 64'd1;
            end
            default: ;
         endcase
         run_checked($sformatf("rand%0d", i), f3, a, b, rd, model(f3, a, b), model_lat(f3, a, b));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
